// File: rtl/button_conditioner.sv
// Button input conditioning: two-flop synchronizer, debounce, press detection,
// left/right auto-repeat and arbitration into single-cycle move/drop strobes.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 3750000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_right_raw,
  input  logic       btn_left_raw,
  input  logic       btn_drop_raw,
  output logic       move_right,
  output logic       move_left,
  output logic       drop_piece,
  output logic [6:0] o_dbg_state
);

  // Button index: 0 = right, 1 = left, 2 = drop.
  localparam int NB = 3;
  localparam int NR = 2;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    r_sync1;
  logic [NB-1:0]    r_sync2;
  logic [NB-1:0]    r_stable;
  logic [NB-1:0]    w_stable_nxt;
  logic [NB-1:0]    w_press;
  logic [CNT_W-1:0] r_db_cnt     [NB];
  logic [CNT_W-1:0] w_db_cnt_nxt [NB];

  rpt_state_t       r_state      [NR];
  rpt_state_t       w_state_nxt  [NR];
  logic [CNT_W-1:0] r_tmr        [NR];
  logic [CNT_W-1:0] w_tmr_nxt    [NR];
  logic [NR-1:0]    w_fire;

  logic             w_move_block;
  logic             r_move_right;
  logic             r_move_left;
  logic             r_drop_piece;

  assign w_raw = {btn_drop_raw, btn_left_raw, btn_right_raw};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stable state flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      w_db_cnt_nxt[i] = '0;
      w_stable_nxt[i] = r_stable[i];
      if (r_sync2[i] != r_stable[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_stable_nxt[i] = r_sync2[i];
        end else begin
          w_db_cnt_nxt[i] = r_db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign w_press = ~r_stable & w_stable_nxt;

  // Stable resets to "pressed" so a button held through reset stays silent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stable <= '1;
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= w_db_cnt_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        r_state[i] <= ST_IDLE;
        r_tmr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_tmr[i]   <= w_tmr_nxt[i];
      end
    end
  end

  // Release is checked first, so it wins over a strobe due in the same cycle.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      w_state_nxt[i] = r_state[i];
      w_tmr_nxt[i]   = r_tmr[i];
      w_fire[i]      = 1'b0;
      case (r_state[i])
        ST_IDLE: begin
          w_tmr_nxt[i] = '0;
          if (w_press[i]) begin
            w_fire[i]      = 1'b1;
            w_state_nxt[i] = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (!r_stable[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_tmr_nxt[i]   = '0;
          end else if (r_tmr[i] == RD_LAST) begin
            w_fire[i]      = 1'b1;
            w_state_nxt[i] = ST_REPEAT;
            w_tmr_nxt[i]   = '0;
          end else begin
            w_tmr_nxt[i] = r_tmr[i] + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!r_stable[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_tmr_nxt[i]   = '0;
          end else if (r_tmr[i] == RP_LAST) begin
            w_fire[i]    = 1'b1;
            w_tmr_nxt[i] = '0;
          end else begin
            w_tmr_nxt[i] = r_tmr[i] + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_tmr_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Moves are blocked while both directions are held (post-edge stable states,
  // so a simultaneous double press is caught), when both would fire together,
  // or when drop fires. Blocked strobes are dropped; the timers are untouched.
  assign w_move_block = (w_stable_nxt[0] & w_stable_nxt[1]) |
                        (w_fire[0] & w_fire[1]) |
                        w_press[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_move_right <= 1'b0;
      r_move_left  <= 1'b0;
      r_drop_piece <= 1'b0;
    end else begin
      r_move_right <= w_fire[0] & ~w_move_block;
      r_move_left  <= w_fire[1] & ~w_move_block;
      r_drop_piece <= w_press[2];
    end
  end

  assign move_right  = r_move_right;
  assign move_left   = r_move_left;
  assign drop_piece  = r_drop_piece;
  assign o_dbg_state = {r_stable, r_state[1], r_state[0]};

endmodule
